rocker_array: RTL and testbench

Parametrised N-channel joystick front end for the slave board; replaces the per-stick rocker instances and the shared clock divider with one SPI engine polling up to N_CH joystick modules round-robin. Each poll reads 10-bit X/Y and button state per stick, then converts them into registered left/right/up/down/click flags with hysteresis. The flags feed the existing sender path toward the master board.

---
 rtl/rocker_pkg.sv | 21 ++
 rtl/spi_byte_shifter.sv | 62 ++++++
 rtl/rocker_array.sv | 175 +++++++++++++++++
 tb/tb_rocker_array.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rocker_pkg.sv
// Shared types and constants for the multi-channel joystick SPI poller.
package rocker_pkg;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_SELECT,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam int         BYTES_PER_TXN = 5;
  localparam logic [5:0] CMD_PREFIX    = 6'b100000;

  localparam logic [2:0] BYTE_X_LO = 3'd0;
  localparam logic [2:0] BYTE_X_HI = 3'd1;
  localparam logic [2:0] BYTE_Y_LO = 3'd2;
  localparam logic [2:0] BYTE_Y_HI = 3'd3;
  localparam logic [2:0] BYTE_BTN  = 3'(BYTES_PER_TXN - 1);

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI byte engine: one start pulse shifts 8 bits MSB-first with sclk at SCLK_DIV.
module spi_byte_shifter #(
  parameter int SCLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       sclk,
  output logic       mosi
);

  localparam int DIV_W = $clog2(SCLK_DIV);

  logic             busy;
  logic             tick;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sh;

  assign tick = busy && (div_cnt == DIV_W'(SCLK_DIV - 1));
  // done coincides with the final falling edge so the caller can react on the same clock
  assign done = tick && sclk && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
    end else if (!busy) begin
      if (start) begin
        busy    <= 1'b1;
        tx_sh   <= tx_byte;
        mosi    <= tx_byte[7];
        div_cnt <= '0;
        bit_cnt <= '0;
      end
    end else if (!tick) begin
      div_cnt <= div_cnt + 1'b1;
    end else begin
      div_cnt <= '0;
      sclk    <= ~sclk;
      if (sclk) begin
        tx_sh   <= {tx_sh[6:0], 1'b0};
        mosi    <= done ? 1'b0 : tx_sh[6];
        bit_cnt <= bit_cnt + 1'b1;
        if (done) busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tick && !sclk) rx_byte <= {rx_byte[6:0], miso};
  end

endmodule

// File: rtl/rocker_array.sv
// Round-robin SPI poller for N_CH joysticks; turns raw X/Y/button into hysteretic direction flags.
module rocker_array
  import rocker_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int SCLK_DIV = 50,
  parameter int BYTE_GAP = 1500,
  parameter int POLL_GAP = 100000,
  parameter int LOW_TH   = 300,
  parameter int HIGH_TH  = 700,
  parameter int HYST     = 32,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      miso,
  output logic [N_CH-1:0]      ss,
  output logic                 sclk,
  output logic                 mosi,
  input  logic [2*N_CH-1:0]    led,
  output logic [N_CH-1:0]      left,
  output logic [N_CH-1:0]      right,
  output logic [N_CH-1:0]      up,
  output logic [N_CH-1:0]      down,
  output logic [N_CH-1:0]      click,
  output logic [10*N_CH-1:0]   x_pos,
  output logic [10*N_CH-1:0]   y_pos,
  output logic                 sample_valid,
  output logic [CH_W-1:0]      sample_ch
);

  localparam int GAP_MAX = (POLL_GAP > BYTE_GAP) ? POLL_GAP : BYTE_GAP;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);

  state_t           state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [2:0]       byte_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic [N_CH-1:0]  ss_d;
  logic             start, shift_done, miso_sel;
  logic [7:0]       tx_byte, rx_byte;
  logic [1:0]       led_pair;
  logic [9:0]       x_buf, y_buf;
  logic             btn_buf;

  function automatic logic low_flag(input logic [9:0] v, input logic prev);
    if (v < 10'(LOW_TH)) return 1'b1;
    if (v >= 10'(LOW_TH + HYST)) return 1'b0;
    return prev;
  endfunction

  function automatic logic high_flag(input logic [9:0] v, input logic prev);
    if (v > 10'(HIGH_TH)) return 1'b1;
    if (v <= 10'(HIGH_TH - HYST)) return 1'b0;
    return prev;
  endfunction

  always_comb begin
    led_pair = 2'b00;
    miso_sel = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_q == CH_W'(i)) begin
        led_pair = led[2*i +: 2];
        miso_sel = miso[i];
      end
    end
  end

  spi_byte_shifter #(.SCLK_DIV(SCLK_DIV)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_byte (tx_byte),
    .miso    (miso_sel),
    .done    (shift_done),
    .rx_byte (rx_byte),
    .sclk    (sclk),
    .mosi    (mosi)
  );

  // Byte 0 is only ever started from SELECT, so the live LED pair is what gets loaded.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    start   = 1'b0;
    tx_byte = 8'h00;
    unique case (state_q)
      ST_WAIT: if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
        state_d = ST_SELECT;
        ch_d    = '0;
      end
      ST_SELECT: if (gap_cnt == GAP_W'(BYTE_GAP - 1)) begin
        start   = 1'b1;
        tx_byte = {CMD_PREFIX, led_pair};
        state_d = ST_SHIFT;
      end
      ST_SHIFT: if (shift_done) state_d = (byte_idx == BYTE_BTN) ? ST_DONE : ST_GAP;
      ST_GAP: if (gap_cnt == GAP_W'(BYTE_GAP - 1)) begin
        start   = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_DONE: begin
        if (ch_q == CH_W'(N_CH - 1)) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_SELECT;
          ch_d    = ch_q + 1'b1;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    ss_d = '1;
    for (int i = 0; i < N_CH; i++) begin
      if ((state_d == ST_SELECT || state_d == ST_SHIFT || state_d == ST_GAP) && ch_d == CH_W'(i))
        ss_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_WAIT;
      ch_q         <= '0;
      byte_idx     <= '0;
      gap_cnt      <= '0;
      ss           <= '1;
      left         <= '0;
      right        <= '0;
      up           <= '0;
      down         <= '0;
      click        <= '0;
      x_pos        <= '0;
      y_pos        <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      ss           <= ss_d;
      sample_valid <= 1'b0;
      gap_cnt      <= (state_d == state_q && state_q != ST_SHIFT) ? gap_cnt + 1'b1 : '0;
      if (state_q == ST_SELECT) byte_idx <= '0;
      else if (state_q == ST_SHIFT && shift_done) byte_idx <= byte_idx + 1'b1;
      if (state_q == ST_DONE) begin
        sample_valid <= 1'b1;
        sample_ch    <= ch_q;
        for (int i = 0; i < N_CH; i++) begin
          if (ch_q == CH_W'(i)) begin
            x_pos[10*i +: 10] <= x_buf;
            y_pos[10*i +: 10] <= y_buf;
            click[i]          <= btn_buf;
            left[i]           <= low_flag(x_buf, left[i]);
            right[i]          <= high_flag(x_buf, right[i]);
            down[i]           <= low_flag(y_buf, down[i]);
            up[i]             <= high_flag(y_buf, up[i]);
          end
        end
      end
    end
  end

  // Receive assembly; every field is rewritten before DONE so no reset is needed.
  always_ff @(posedge clk) begin
    if (state_q == ST_SHIFT && shift_done) begin
      unique case (byte_idx)
        BYTE_X_LO: x_buf[7:0] <= rx_byte;
        BYTE_X_HI: x_buf[9:8] <= rx_byte[1:0];
        BYTE_Y_LO: y_buf[7:0] <= rx_byte;
        BYTE_Y_HI: y_buf[9:8] <= rx_byte[1:0];
        default:   btn_buf    <= rx_byte[0];
      endcase
    end
  end

endmodule

// File: tb/tb_rocker_array.sv
// Directed bench for rocker_array: SPI joystick model per channel and hand-computed expectations.
module tb_rocker_array;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  miso;
  logic [1:0]  ss;
  logic        sclk, mosi;
  logic [3:0]  led = 4'b0000;
  logic [1:0]  left, right, up, down, click;
  logic [19:0] x_pos, y_pos;
  logic        sample_valid;
  logic        sample_ch;

  int          tests = 0;
  int          fails = 0;

  logic [39:0] resp [2];
  int          fcnt [2];
  logic [7:0]  mosi_cap [2];
  logic        sclk_q = 1'b0;

  rocker_array #(
    .N_CH(2), .SCLK_DIV(2), .BYTE_GAP(4), .POLL_GAP(20)
  ) dut (
    .clk(clk), .rst(rst), .miso(miso), .ss(ss), .sclk(sclk), .mosi(mosi), .led(led),
    .left(left), .right(right), .up(up), .down(down), .click(click),
    .x_pos(x_pos), .y_pos(y_pos), .sample_valid(sample_valid), .sample_ch(sample_ch)
  );

  always #5 clk = ~clk;

  // Stick model: presents the next bit after each sclk fall; records the first mosi byte.
  always @(posedge clk) begin
    sclk_q <= sclk;
    for (int c = 0; c < 2; c++) begin
      if (ss[c]) fcnt[c] <= 0;
      else if (sclk_q && !sclk) fcnt[c] <= fcnt[c] + 1;
      if (!ss[c] && !sclk_q && sclk && fcnt[c] < 8) mosi_cap[c] <= {mosi_cap[c][6:0], mosi};
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      miso[c] = 1'b0;
      if (fcnt[c] < 40) miso[c] = resp[c][6'(39 - fcnt[c])];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_resp(input int c, input logic [9:0] x, input logic [9:0] y, input logic btn);
    resp[c] = {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 7'b0, btn};
  endtask

  task automatic wait_ch(input int target, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (sample_valid && 32'(sample_ch) == target) hit = 1'b1;
    end
    check({tag, "_seen"}, 32'(hit), 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("ss_onehot", 32'($countones(~ss) <= 1), 32'd1);
      check("lr_excl", 32'(left & right), 32'd0);
      check("ud_excl", 32'(up & down), 32'd0);
    end
  end

  initial begin
    int n;
    fcnt[0] = 0; fcnt[1] = 0;
    mosi_cap[0] = 8'h00; mosi_cap[1] = 8'h00;
    set_resp(0, 10'd512, 10'd512, 1'b0);
    set_resp(1, 10'd512, 10'd512, 1'b0);

    repeat (3) @(negedge clk);
    check("rst_ss", 32'(ss), 32'd3);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_ch", 32'(sample_ch), 32'd0);
    check("rst_flags", 32'({left, right, up, down, click}), 32'd0);
    check("rst_xpos", 32'(x_pos), 32'd0);
    check("rst_ypos", 32'(y_pos), 32'd0);

    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("wait_ss", 32'(ss), 32'd3);
    n = 0;
    while (ss == 2'b11 && n < 100) begin @(negedge clk); n++; end
    check("sel0_ss", 32'(ss), 32'b10);
    wait_ch(0, "base0");
    check("base0_x", 32'(x_pos[9:0]), 32'd512);
    check("base0_y", 32'(y_pos[9:0]), 32'd512);
    check("base0_flags", 32'({left, right, up, down, click}), 32'd0);
    check("sel1_ss", 32'(ss), 32'b01);
    wait_ch(1, "base1");
    check("base1_x", 32'(x_pos[19:10]), 32'd512);
    check("base1_flags", 32'({left, right, up, down, click}), 32'd0);
    @(negedge clk);
    check("pulse_len", 32'(sample_valid), 32'd0);
    check("idle_ss", 32'(ss), 32'd3);

    set_resp(0, 10'd100, 10'd512, 1'b0);
    wait_ch(0, "x100");
    check("x100_left", 32'(left[0]), 32'd1);
    check("x100_right", 32'(right[0]), 32'd0);
    check("x100_x", 32'(x_pos[9:0]), 32'd100);
    set_resp(0, 10'd320, 10'd512, 1'b0);
    wait_ch(0, "x320");
    check("x320_left", 32'(left[0]), 32'd1);
    set_resp(0, 10'd332, 10'd512, 1'b0);
    wait_ch(0, "x332");
    check("x332_left", 32'(left[0]), 32'd0);
    set_resp(0, 10'd701, 10'd512, 1'b0);
    wait_ch(0, "x701");
    check("x701_right", 32'(right[0]), 32'd1);
    set_resp(0, 10'd669, 10'd512, 1'b0);
    wait_ch(0, "x669");
    check("x669_right", 32'(right[0]), 32'd1);
    set_resp(0, 10'd668, 10'd512, 1'b0);
    wait_ch(0, "x668");
    check("x668_right", 32'(right[0]), 32'd0);

    set_resp(1, 10'd512, 10'd900, 1'b1);
    wait_ch(1, "y900");
    check("y900_up", 32'(up[1]), 32'd1);
    check("y900_click", 32'(click[1]), 32'd1);
    check("y900_ypos", 32'(y_pos[19:10]), 32'd900);
    check("y900_down", 32'(down[1]), 32'd0);
    check("ch0_hold_x", 32'(x_pos[9:0]), 32'd668);
    check("ch0_hold_flags", 32'({left[0], right[0], up[0], down[0], click[0]}), 32'd0);
    set_resp(1, 10'd512, 10'd299, 1'b0);
    wait_ch(1, "y299");
    check("y299_down", 32'(down[1]), 32'd1);
    check("y299_up", 32'(up[1]), 32'd0);
    check("y299_click", 32'(click[1]), 32'd0);

    led = 4'b1101;
    wait_ch(0, "led0");
    check("led0_byte", 32'(mosi_cap[0]), 32'h81);
    wait_ch(1, "led1");
    check("led1_byte", 32'(mosi_cap[1]), 32'h83);

    set_resp(0, 10'd100, 10'd512, 1'b0);
    n = 0;
    while (ss != 2'b10 && n < 1000) begin @(negedge clk); n++; end
    check("rst_sel0", 32'(ss), 32'b10);
    n = 0;
    while (fcnt[0] < 20 && n < 1000) begin @(negedge clk); n++; end
    check("rst_byte2", 32'(fcnt[0]), 32'd20);
    rst = 1'b0;
    #1;
    check("arst_ss", 32'(ss), 32'd3);
    check("arst_sclk", 32'(sclk), 32'd0);
    check("arst_flags", 32'({left, right, up, down, click}), 32'd0);
    check("arst_valid", 32'(sample_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (ss != 2'b11) break;
    end
    check("restart_gap", 32'(n), 32'd20);
    check("restart_ss", 32'(ss), 32'b10);
    wait_ch(0, "restart");
    check("restart_x", 32'(x_pos[9:0]), 32'd100);
    check("restart_left", 32'(left[0]), 32'd1);
    check("restart_down1", 32'(down[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
